// File: rtl/bitbang_cfg_tx_pkg.sv
// rtl/bitbang_cfg_tx_pkg.sv - shared types and constants for the bitbang config transmitter.
package bitbang_cfg_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LOW,
    HIGH
  } state_e;

  localparam logic [31:0] DATA_OFS   = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int OVF_BIT  = 31;
  localparam int BUSY_BIT = 30;
  localparam int DONE_BIT = 29;

  localparam int FRAME_BITS = 48;

endpackage

// File: rtl/bitbang_cfg_tx_fifo.sv
// rtl/bitbang_cfg_tx_fifo.sv - synchronous word FIFO; a push on a full FIFO is taken only with a pop.
module bitbang_cfg_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign level_o = level_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/bitbang_cfg_tx.sv
// rtl/bitbang_cfg_tx.sv - Wishbone-fed transmitter serialising {word, CTRL_WORD} frames on s_clk/s_data.
// Define BITBANG_CFG_TX_IRQ_EN to add the irq output and the sticky STATUS done flag.
module bitbang_cfg_tx
  import bitbang_cfg_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CLK_DIV    = 2,
  parameter logic [15:0] CTRL_WORD  = 16'hFAB1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        s_clk,
  output logic        s_data,
  output logic        busy
`ifdef BITBANG_CFG_TX_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  state_e                  state_q, state_d;
  logic [DW-1:0]           div_q, div_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic                    ack_q, ack_d;
  logic [31:0]             dat_q, dat_d;
  logic                    ovf_q, ovf_d;

  logic        sel_data, sel_status, hit;
  logic        wr_data, wr_status, rd_status;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0] fifo_rdata;
  logic [LW-1:0] fifo_level;
  logic        done_bit;
  logic [31:0] status_word;
  logic        unused_sel;

  assign unused_sel = ^wbs_sel_i;

  // Register side effects happen on the edge that raises ack, so each ack maps to exactly one action.
  assign sel_data   = (wbs_adr_i == BASE_ADDR + DATA_OFS);
  assign sel_status = (wbs_adr_i == BASE_ADDR + STATUS_OFS);
  assign hit        = wbs_stb_i & wbs_cyc_i & (sel_data | sel_status);
  assign ack_d      = hit & ~ack_q;
  assign wr_data    = ack_d & wbs_we_i & sel_data;
  assign wr_status  = ack_d & wbs_we_i & sel_status;
  assign rd_status  = ack_d & ~wbs_we_i & sel_status;

  assign fifo_push = wr_data & (~fifo_full | fifo_pop);
  assign ovf_d     = (ovf_q & ~(wr_status & wbs_dat_i[OVF_BIT])) | (wr_data & fifo_full & ~fifo_pop);

  assign busy        = ~fifo_empty | (state_q != IDLE);
  assign status_word = {ovf_q, busy, done_bit, 13'b0, 16'(fifo_level)};
  assign dat_d       = rd_status ? status_word : 32'b0;

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign s_clk     = (state_q == HIGH);
  assign s_data    = ((state_q == LOW) || (state_q == HIGH)) & shreg_q[FRAME_BITS-1];

  bitbang_cfg_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (fifo_push),
    .data_i  (wbs_dat_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        fifo_pop = 1'b1;
        shreg_d  = {fifo_rdata, CTRL_WORD};
        bit_d    = BIT_LAST;
        div_d    = '0;
        state_d  = LOW;
      end
      LOW: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
          if (bit_q == '0) begin
            state_d = fifo_empty ? IDLE : LOAD;
          end else begin
            bit_d   = bit_q - 1'b1;
            state_d = LOW;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef BITBANG_CFG_TX_IRQ_EN
  logic busy_q, irq_q, done_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      busy_q <= 1'b0;
      irq_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy;
      irq_q  <= busy_q & ~busy;
      done_q <= (busy_q & ~busy) | (done_q & ~(wr_status & wbs_dat_i[DONE_BIT]));
    end
  end

  assign irq      = irq_q;
  assign done_bit = done_q;
`else
  assign done_bit = 1'b0;
`endif

endmodule
